// File: rtl/pc_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl_pkg
// Shared definitions for the PC redirect controller: default datapath width,
// drain counter width, FSM state encodings and the target alignment helper.
// ---------------------------------------------------------------------------
package pc_redirect_ctrl_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int REDIR_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    REDIR_IDLE  = 2'd0,
    REDIR_ISSUE = 2'd1,
    REDIR_DRAIN = 2'd2
  } redir_state_e;

  // Without compressed instructions every target must be 4-byte aligned;
  // bit0 is always cleared or zero, so bit1 alone decides.
  function automatic logic target_misaligned(input logic [1:0] low_bits);
    return low_bits[1];
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_target_calc.sv
// ---------------------------------------------------------------------------
// redir_target_calc
// Combinational JALR target adder, bit0 clear, misalignment detect and the
// trap > jalr > br priority mux.
// Ports:
//   trap_req/trap_pc        trap redirect (never alignment-checked)
//   jalr_req/jalr_rs1/imm   JALR operands; target = (rs1 + imm) & ~1
//   br_req/br_pc            branch/JAL precomputed target
//   winner_valid            some request is present
//   winner_pc               target of the highest-priority request
//   winner_misaligned       winning jalr/br target has bit1 set
// ---------------------------------------------------------------------------
module redir_target_calc
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            jalr_req,
  input  logic [XLEN-1:0] jalr_rs1,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic            br_req,
  input  logic [XLEN-1:0] br_pc,
  output logic            winner_valid,
  output logic [XLEN-1:0] winner_pc,
  output logic            winner_misaligned
);

  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] jalr_tgt_s;

  // JALR target: wrapping add, then force bit0 low.
  always_comb begin
    jalr_sum_s = jalr_rs1 + jalr_imm;
    jalr_tgt_s = {jalr_sum_s[XLEN-1:1], 1'b0};
  end

  // Priority select; a trap target is taken as-is with no alignment check.
  always_comb begin
    winner_valid      = 1'b0;
    winner_pc         = {XLEN{1'b0}};
    winner_misaligned = 1'b0;
    if (trap_req) begin
      winner_valid      = 1'b1;
      winner_pc         = trap_pc;
      winner_misaligned = 1'b0;
    end else if (jalr_req) begin
      winner_valid      = 1'b1;
      winner_pc         = jalr_tgt_s;
      winner_misaligned = target_misaligned(jalr_tgt_s[1:0]);
    end else if (br_req) begin
      winner_valid      = 1'b1;
      winner_pc         = br_pc;
      winner_misaligned = target_misaligned(br_pc[1:0]);
    end else begin
      winner_valid      = 1'b0;
      winner_pc         = {XLEN{1'b0}};
      winner_misaligned = 1'b0;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
// Sequences trap / JALR / branch redirects into fetch with a valid/ready
// handshake, then holds IF/ID in flush for FLUSH_CYCLES after the accept.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   trap_req, trap_pc        trap redirect (preempts ISSUE and DRAIN)
//   jalr_req, jalr_rs1/imm   JALR request and operands
//   br_req, br_pc            taken branch / JAL request and target
//   redir_valid, redir_pc    redirect offered to fetch (registered)
//   redir_ready              fetch accepts the redirect
//   flush_o                  kill IF/ID contents (ISSUE and DRAIN)
//   busy_o                   controller not in IDLE
//   misalign_o, misalign_pc  one-cycle misaligned-target report
// All outputs are registered; redir_ready only affects next-state values.
// ---------------------------------------------------------------------------
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            jalr_req,
  input  logic [XLEN-1:0] jalr_rs1,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic            br_req,
  input  logic [XLEN-1:0] br_pc,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ready,
  output logic            flush_o,
  output logic            busy_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_pc
);

  localparam logic [REDIR_CNT_WIDTH-1:0] CNT_LOAD = REDIR_CNT_WIDTH'(FLUSH_CYCLES);
  localparam logic [REDIR_CNT_WIDTH-1:0] CNT_ONE  = {{(REDIR_CNT_WIDTH-1){1'b0}}, 1'b1};

  redir_state_e                state_r, state_s;
  logic [REDIR_CNT_WIDTH-1:0]  cnt_r, cnt_s;
  logic                        redir_valid_s;
  logic [XLEN-1:0]             redir_pc_s;
  logic                        flush_s;
  logic                        busy_s;
  logic                        misalign_s;
  logic [XLEN-1:0]             misalign_pc_s;

  logic                        winner_valid_s;
  logic [XLEN-1:0]             winner_pc_s;
  logic                        winner_misaligned_s;

  redir_target_calc #(.XLEN(XLEN)) u_target_calc (
    .trap_req          (trap_req),
    .trap_pc           (trap_pc),
    .jalr_req          (jalr_req),
    .jalr_rs1          (jalr_rs1),
    .jalr_imm          (jalr_imm),
    .br_req            (br_req),
    .br_pc             (br_pc),
    .winner_valid      (winner_valid_s),
    .winner_pc         (winner_pc_s),
    .winner_misaligned (winner_misaligned_s)
  );

  // State, drain counter and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= REDIR_IDLE;
      cnt_r       <= {REDIR_CNT_WIDTH{1'b0}};
      redir_valid <= 1'b0;
      redir_pc    <= {XLEN{1'b0}};
      flush_o     <= 1'b0;
      busy_o      <= 1'b0;
      misalign_o  <= 1'b0;
      misalign_pc <= {XLEN{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      redir_valid <= redir_valid_s;
      redir_pc    <= redir_pc_s;
      flush_o     <= flush_s;
      busy_o      <= busy_s;
      misalign_o  <= misalign_s;
      misalign_pc <= misalign_pc_s;
    end
  end

  // Next state and next registered output values; outputs follow the state
  // being entered so they line up with state_r one cycle later.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    redir_valid_s = redir_valid;
    redir_pc_s    = redir_pc;
    flush_s       = flush_o;
    busy_s        = busy_o;
    misalign_s    = 1'b0;
    misalign_pc_s = misalign_pc;

    case (state_r)
      REDIR_IDLE: begin
        redir_valid_s = 1'b0;
        flush_s       = 1'b0;
        busy_s        = 1'b0;
        if (winner_valid_s && !winner_misaligned_s) begin
          state_s       = REDIR_ISSUE;
          redir_pc_s    = winner_pc_s;
          redir_valid_s = 1'b1;
          flush_s       = 1'b1;
          busy_s        = 1'b1;
        end else if (winner_valid_s) begin
          // Misaligned jalr/br: report only, the trap unit follows up.
          misalign_s    = 1'b1;
          misalign_pc_s = winner_pc_s;
        end else begin
          state_s = REDIR_IDLE;
        end
      end

      REDIR_ISSUE: begin
        flush_s = 1'b1;
        busy_s  = 1'b1;
        if (trap_req) begin
          // A same-cycle handshake still completes; fetch then sees the trap.
          state_s       = REDIR_ISSUE;
          redir_pc_s    = trap_pc;
          redir_valid_s = 1'b1;
        end else if (redir_valid && redir_ready) begin
          state_s       = REDIR_DRAIN;
          cnt_s         = CNT_LOAD;
          redir_valid_s = 1'b0;
        end else begin
          redir_valid_s = 1'b1;
        end
      end

      REDIR_DRAIN: begin
        redir_valid_s = 1'b0;
        flush_s       = 1'b1;
        busy_s        = 1'b1;
        if (trap_req) begin
          state_s       = REDIR_ISSUE;
          redir_pc_s    = trap_pc;
          redir_valid_s = 1'b1;
        end else if (cnt_r <= CNT_ONE) begin
          state_s = REDIR_IDLE;
          cnt_s   = {REDIR_CNT_WIDTH{1'b0}};
          flush_s = 1'b0;
          busy_s  = 1'b0;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      default: begin
        state_s       = REDIR_IDLE;
        cnt_s         = {REDIR_CNT_WIDTH{1'b0}};
        redir_valid_s = 1'b0;
        flush_s       = 1'b0;
        busy_s        = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl
// Directed stimulus; expected accepted redirect targets and misalign reports
// are queued by the stimulus and popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic        jalr_req;
  logic [31:0] jalr_rs1;
  logic [31:0] jalr_imm;
  logic        br_req;
  logic [31:0] br_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;
  logic        flush_o;
  logic        busy_o;
  logic        misalign_o;
  logic [31:0] misalign_pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_redir_q[$];
  logic [31:0] exp_mis_q[$];

  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .trap_req    (trap_req),
    .trap_pc     (trap_pc),
    .jalr_req    (jalr_req),
    .jalr_rs1    (jalr_rs1),
    .jalr_imm    (jalr_imm),
    .br_req      (br_req),
    .br_pc       (br_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .redir_ready (redir_ready),
    .flush_o     (flush_o),
    .busy_o      (busy_o),
    .misalign_o  (misalign_o),
    .misalign_pc (misalign_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    trap_req = 1'b0;
    jalr_req = 1'b0;
    br_req   = 1'b0;
  endtask

  // Count valid/flush cycles from the current cycle until busy_o drops.
  task automatic run_until_idle(output int vc, output int fc);
    vc = 0;
    fc = 0;
    for (int i = 0; i < 40 && busy_o; i++) begin
      if (redir_valid) vc++;
      if (flush_o) fc++;
      tick();
    end
    check("idle_reached", {31'd0, busy_o}, 32'd0);
    check("flush_low_in_idle", {31'd0, flush_o}, 32'd0);
  endtask

  // Monitor: redirect accepted / misalign reported in the cycle before the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && redir_valid && redir_ready) begin
        if (exp_redir_q.size() == 0) begin
          check("unexpected_redirect", redir_pc, 32'hDEAD_BEEF);
        end else begin
          check("accepted_pc", redir_pc, exp_redir_q.pop_front());
        end
      end
      if (!rst && misalign_o) begin
        if (exp_mis_q.size() == 0) begin
          check("unexpected_misalign", misalign_pc, 32'hDEAD_BEEF);
        end else begin
          check("misalign_pc", misalign_pc, exp_mis_q.pop_front());
        end
      end
    end
  end

  initial begin
    int vc;
    int fc;
    int stable;

    rst = 1'b1; redir_ready = 1'b0;
    trap_pc = 32'd0; jalr_rs1 = 32'd0; jalr_imm = 32'd0; br_pc = 32'd0;
    clear_reqs();
    tick(); tick();
    check("rst_valid", {31'd0, redir_valid}, 32'd0);
    check("rst_pc", redir_pc, 32'd0);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    check("rst_misalign_pc", misalign_pc, 32'd0);
    rst = 1'b0;
    tick();

    // JALR 0x1000 + 0xFF5 -> 0x1FF4, accepted immediately.
    jalr_req = 1'b1; jalr_rs1 = 32'h0000_1000; jalr_imm = 32'h0000_0FF5; redir_ready = 1'b1;
    exp_redir_q.push_back(32'h0000_1FF4);
    tick();
    clear_reqs();
    check("jalr_valid", {31'd0, redir_valid}, 32'd1);
    check("jalr_pc", redir_pc, 32'h0000_1FF4);
    check("jalr_busy", {31'd0, busy_o}, 32'd1);
    run_until_idle(vc, fc);
    check("jalr_valid_cycles", vc, 32'd1);
    check("jalr_flush_cycles", fc, 32'd3);

    // Misaligned branch target: report only, no redirect.
    br_req = 1'b1; br_pc = 32'h0000_0206;
    exp_mis_q.push_back(32'h0000_0206);
    tick();
    clear_reqs();
    check("mis_pulse", {31'd0, misalign_o}, 32'd1);
    check("mis_pc_out", misalign_pc, 32'h0000_0206);
    check("mis_no_valid", {31'd0, redir_valid}, 32'd0);
    check("mis_not_busy", {31'd0, busy_o}, 32'd0);
    tick();
    check("mis_one_cycle", {31'd0, misalign_o}, 32'd0);
    check("mis_still_idle", {31'd0, busy_o}, 32'd0);

    // Branch 0x400 with fetch stalled for 4 cycles.
    br_req = 1'b1; br_pc = 32'h0000_0400; redir_ready = 1'b0;
    exp_redir_q.push_back(32'h0000_0400);
    tick();
    clear_reqs();
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      if (redir_valid && redir_pc == 32'h0000_0400 && flush_o && busy_o) stable++;
      if (i == 4) redir_ready = 1'b1;
      else tick();
    end
    check("br_stall_stable_cycles", stable, 32'd5);
    run_until_idle(vc, fc);
    check("br_stall_valid_after_ready", vc, 32'd1);
    check("br_stall_flush_cycles", fc, 32'd3);

    // JALR to 0x200, then trap in DRAIN alongside an ignored JALR.
    jalr_req = 1'b1; jalr_rs1 = 32'h0000_0100; jalr_imm = 32'h0000_0100;
    exp_redir_q.push_back(32'h0000_0200);
    tick();
    clear_reqs();
    check("jalr200_pc", redir_pc, 32'h0000_0200);
    tick();
    check("drain_no_valid", {31'd0, redir_valid}, 32'd0);
    check("drain_flush", {31'd0, flush_o}, 32'd1);
    trap_req = 1'b1; trap_pc = 32'h0000_0080;
    jalr_req = 1'b1; jalr_rs1 = 32'h0000_0000; jalr_imm = 32'h0000_0300;
    exp_redir_q.push_back(32'h0000_0080);
    tick();
    clear_reqs();
    check("trap_drain_valid", {31'd0, redir_valid}, 32'd1);
    check("trap_drain_pc", redir_pc, 32'h0000_0080);
    run_until_idle(vc, fc);
    check("trap_drain_flush_cycles", fc, 32'd3);

    // Trap during the ISSUE handshake cycle: old completes, trap reissued.
    br_req = 1'b1; br_pc = 32'h0000_0500;
    exp_redir_q.push_back(32'h0000_0500);
    tick();
    br_req = 1'b0;
    trap_req = 1'b1; trap_pc = 32'h0000_0600;
    exp_redir_q.push_back(32'h0000_0600);
    tick();
    clear_reqs();
    check("trap_hs_valid", {31'd0, redir_valid}, 32'd1);
    check("trap_hs_pc", redir_pc, 32'h0000_0600);
    run_until_idle(vc, fc);
    check("trap_hs_flush_cycles", fc, 32'd3);

    // Trap and misaligned JALR together: trap wins, no misalign report.
    trap_req = 1'b1; trap_pc = 32'h0000_0100;
    jalr_req = 1'b1; jalr_rs1 = 32'hFFFF_FFFE; jalr_imm = 32'h0000_0004;
    exp_redir_q.push_back(32'h0000_0100);
    tick();
    clear_reqs();
    check("trap_jalr_pc", redir_pc, 32'h0000_0100);
    check("trap_jalr_no_misalign", {31'd0, misalign_o}, 32'd0);
    run_until_idle(vc, fc);

    // Reset during ISSUE drops the pending redirect.
    br_req = 1'b1; br_pc = 32'h0000_0300; redir_ready = 1'b0;
    tick();
    clear_reqs();
    check("pre_rst_valid", {31'd0, redir_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_issue_valid", {31'd0, redir_valid}, 32'd0);
    check("rst_issue_pc", redir_pc, 32'd0);
    check("rst_issue_flush", {31'd0, flush_o}, 32'd0);
    check("rst_issue_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0; redir_ready = 1'b1;
    tick(); tick();
    check("post_rst_valid", {31'd0, redir_valid}, 32'd0);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);

    tick();
    check("redir_queue_drained", exp_redir_q.size(), 32'd0);
    check("mis_queue_drained", exp_mis_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
